// File: rtl/f8_ram_arbiter.sv
// Two-master arbiter (f8 core + DMA/debug) in front of the single-port system RAM.
// Latency: request seen at posedge E1 -> RAM access in the following cycle -> ack in the cycle after E2.
// Backpressure: the losing master holds its request until granted (round-robin, one foreign access at most).
// Ports: clk_i/rst_ni; cpu_* and dma_* requester ports (req/we/addr/wdata in, ack/rdata out);
//        mem_* registered RAM-side controls with mem_rdata_i returned the cycle after mem_en;
//        range_err_o pulses alongside the ack of an out-of-range access.
module f8_ram_arbiter #(
  parameter int ADDRWIDTH = 16,
  parameter int RAMSIZE   = 8192
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cpu_req_i,
  input  logic                       cpu_we_i,
  input  logic [ADDRWIDTH-1:0]       cpu_addr_i,
  input  logic [7:0]                 cpu_wdata_i,
  output logic                       cpu_ack_o,
  output logic [7:0]                 cpu_rdata_o,
  input  logic                       dma_req_i,
  input  logic                       dma_we_i,
  input  logic [ADDRWIDTH-1:0]       dma_addr_i,
  input  logic [7:0]                 dma_wdata_i,
  output logic                       dma_ack_o,
  output logic [7:0]                 dma_rdata_o,
  output logic                       mem_en_o,
  output logic                       mem_we_o,
  output logic [$clog2(RAMSIZE)-1:0] mem_addr_o,
  output logic [7:0]                 mem_wdata_o,
  input  logic [7:0]                 mem_rdata_i,
  output logic                       range_err_o
);

  localparam int AW = $clog2(RAMSIZE);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_ACK} state_t;

  state_t          state_q, state_d;
  logic            armed_q;                 // low only until the first posedge after reset release
  logic            last_q, last_d;          // 1 = DMA was granted last
  logic            win_q, win_d;            // 1 = DMA owns the current access
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]      mem_wdata_q, mem_wdata_d;

  logic                 start;
  logic                 grant_dma;
  logic                 sel_we;
  logic [ADDRWIDTH-1:0] sel_addr;
  logic [7:0]           sel_wdata;
  logic                 in_range;

  // Both requesting: the one that did not go last wins.
  assign grant_dma = dma_req_i & (~cpu_req_i | ~last_q);
  assign sel_we    = grant_dma ? dma_we_i    : cpu_we_i;
  assign sel_addr  = grant_dma ? dma_addr_i  : cpu_addr_i;
  assign sel_wdata = grant_dma ? dma_wdata_i : cpu_wdata_i;
  // One extra bit so RAMSIZE == 2**ADDRWIDTH still compares correctly.
  assign in_range  = ({1'b0, sel_addr} < (ADDRWIDTH+1)'(RAMSIZE));
  // Requests present while reset was asserted are not granted on the first edge after release.
  assign start     = (state_q == S_IDLE) & armed_q & (cpu_req_i | dma_req_i);

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; ACK always returns to IDLE without looking at requests
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_MEM;
      S_MEM:   state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next state
  always_comb begin
    last_d      = last_q;
    win_d       = win_q;
    we_d        = we_q;
    err_d       = err_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (start) begin
      last_d = grant_dma;
      win_d  = grant_dma;
      we_d   = sel_we;
      err_d  = ~in_range;
      // Out-of-range accesses never touch the RAM port.
      if (in_range) begin
        mem_en_d    = 1'b1;
        mem_we_d    = sel_we;
        mem_addr_d  = sel_addr[AW-1:0];
        mem_wdata_d = sel_wdata;
      end
    end else if (state_q == S_MEM) begin
      mem_en_d = 1'b0;
      mem_we_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      armed_q     <= 1'b0;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      armed_q     <= 1'b1;
      last_q      <= last_d;
      win_q       <= win_d;
      we_q        <= we_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Outputs: acks decode the ACK state; read data passes straight from the RAM in that cycle.
  always_comb begin
    cpu_ack_o   = 1'b0;
    dma_ack_o   = 1'b0;
    range_err_o = 1'b0;
    cpu_rdata_o = 8'h00;
    dma_rdata_o = 8'h00;
    if (state_q == S_ACK) begin
      cpu_ack_o   = ~win_q;
      dma_ack_o   = win_q;
      range_err_o = err_q;
      if (!we_q && !err_q) begin
        if (win_q) dma_rdata_o = mem_rdata_i;
        else       cpu_rdata_o = mem_rdata_i;
      end
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
